// File: rtl/grf_scoreboard.sv
// grf_scoreboard
//   Pending-write scoreboard at the read end of the general register file.
//   Each register 1..31 owns a saturating counter of outstanding writes.
//   An accepted issue with a non-zero destination increments that counter,
//   and a write-back decrements it. Decode reads are stalled while a source
//   still has an outstanding write. A write retiring this cycle is bypassed
//   by the register file, so it does not block a read of that register.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous active-high reset, overrides all inputs
//   issue_valid   : decode presents an instruction this cycle
//   issue_rs/rt   : source register addresses
//   issue_dst     : destination register address (0 = no write)
//   wb_valid      : write-back writes the register file this cycle
//   wb_addr       : write-back destination address
//   stall         : combinational, the issue is blocked this cycle
//   rs_busy       : combinational, issue_rs has an uncleared pending write
//   rt_busy       : combinational, issue_rt has an uncleared pending write
//   busy_vec      : registered, bit i set while cnt[i] != 0 (bit 0 always 0)
//   err_underflow : registered, sticky, write-back with no pending write
module grf_scoreboard #(
   parameter int unsigned CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rs,
   input  logic [4:0]  issue_rt,
   input  logic [4:0]  issue_dst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   output logic        stall,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic [31:0] busy_vec,
   output logic        err_underflow
);

   localparam logic [CNT_W:0] MAXP = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q [1:31];
   logic [CNT_W-1:0] cnt_d [1:31];
   logic [31:0]      busy_q, busy_d;
   logic             err_q, err_d;

   logic [31:0]      wb_hit;     // retire qualifier per register
   logic [31:0]      eff_busy;   // pending after same-cycle retire bypass
   logic [31:0]      eff_full;   // at MAXP and not retiring this cycle
   logic [31:0]      underflow;  // write-back against an empty counter
   logic             dst_full;
   logic             acc;
   logic [CNT_W:0]   cnt_x;
   logic [CNT_W:0]   cnt_n;
   logic             inc;
   logic             dec;
   logic             iss_here;

   // Per-register views of the current counters
   always_comb begin
      wb_hit    = '0;
      eff_busy  = '0;
      eff_full  = '0;
      underflow = '0;
      cnt_x     = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         cnt_x        = {1'b0, cnt_q[r]};
         wb_hit[r]    = wb_valid && (wb_addr == 5'(r));
         // cnt - wb_hit > 0 without letting 0 - 1 wrap into "busy"
         eff_busy[r]  = cnt_x > {{CNT_W{1'b0}}, wb_hit[r]};
         eff_full[r]  = (cnt_x == MAXP) && !wb_hit[r];
         underflow[r] = wb_hit[r] && (cnt_x == '0);
      end
   end

   always_comb begin
      rs_busy  = eff_busy[issue_rs];
      rt_busy  = eff_busy[issue_rt];
      dst_full = eff_full[issue_dst];
      stall    = issue_valid && (rs_busy || rt_busy || dst_full);
      acc      = issue_valid && !stall;
   end

   // Next-state counters. An issue colliding with a retire of a non-empty
   // counter cancels out. A retire against an empty counter is an error
   // and does not consume the issue, so that issue still increments.
   always_comb begin
      busy_d   = '0;
      err_d    = err_q | (|underflow);
      cnt_n    = '0;
      inc      = 1'b0;
      dec      = 1'b0;
      iss_here = 1'b0;
      for (int unsigned r = 1; r < 32; r++) begin
         iss_here = acc && (issue_dst == 5'(r));
         inc      = iss_here && !(wb_hit[r] && !underflow[r]);
         dec      = wb_hit[r] && !underflow[r] && !iss_here;
         if (inc) begin
            cnt_n = {1'b0, cnt_q[r]} + 1'b1;
         end else if (dec) begin
            cnt_n = {1'b0, cnt_q[r]} - 1'b1;
         end else begin
            cnt_n = {1'b0, cnt_q[r]};
         end
         cnt_d[r]  = cnt_n[CNT_W-1:0];
         busy_d[r] = (cnt_n != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 1; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int unsigned r = 1; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec      = busy_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic [4:0]  issue_dst;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        stall;
   logic        rs_busy;
   logic        rt_busy;
   logic [31:0] busy_vec;
   logic        err_underflow;

   int checks   = 0;
   int failures = 0;

   grf_scoreboard #(.CNT_W(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs      (issue_rs),
      .issue_rt      (issue_rt),
      .issue_dst     (issue_dst),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .stall         (stall),
      .rs_busy       (rs_busy),
      .rt_busy       (rt_busy),
      .busy_vec      (busy_vec),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs; checks of combinational outputs follow after #1
   task automatic drive(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic wv, input logic [4:0] wa);
      issue_valid = iv;
      issue_rs    = rs;
      issue_rt    = rt;
      issue_dst   = dst;
      wb_valid    = wv;
      wb_addr     = wa;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      idle();
      chk("rst_busy_vec", busy_vec, 32'h0);
      chk("rst_err", {31'b0, err_underflow}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_rs_busy", {31'b0, rs_busy}, 32'h0);
      chk("rst_rt_busy", {31'b0, rt_busy}, 32'h0);

      // Basic hold and release on r8
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 5'd0);
      chk("iss8_stall", {31'b0, stall}, 32'h0);
      tick();
      idle();
      chk("iss8_busy_vec", busy_vec, 32'h0000_0100);
      drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 5'd0);
      chk("rs8_stall", {31'b0, stall}, 32'h1);
      chk("rs8_rs_busy", {31'b0, rs_busy}, 32'h1);
      chk("rs8_rt_busy", {31'b0, rt_busy}, 32'h0);
      tick();
      chk("rs8_hold_vec", busy_vec, 32'h0000_0100);
      drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 5'd8);
      chk("rs8_bypass_stall", {31'b0, stall}, 32'h0);
      chk("rs8_bypass_rs_busy", {31'b0, rs_busy}, 32'h0);
      tick();
      idle();
      chk("rel8_busy_vec", busy_vec, 32'h0);

      // rt path on r12
      drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd1, 5'd12, 5'd0, 1'b0, 5'd0);
      chk("rt12_rt_busy", {31'b0, rt_busy}, 32'h1);
      chk("rt12_rs_busy", {31'b0, rs_busy}, 32'h0);
      chk("rt12_stall", {31'b0, stall}, 32'h1);
      tick();
      drive(1'b0, 5'd1, 5'd12, 5'd0, 1'b1, 5'd12);
      chk("rt12_bypass", {31'b0, rt_busy}, 32'h0);
      chk("rt12_novalid_stall", {31'b0, stall}, 32'h0);
      tick();
      idle();
      chk("rel12_busy_vec", busy_vec, 32'h0);

      // Register 0 never busy, write-back to r0 is not an underflow
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      chk("r0_dst_stall", {31'b0, stall}, 32'h0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      chk("r0_src_stall", {31'b0, stall}, 32'h0);
      chk("r0_busy_vec", busy_vec, 32'h0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0);
      tick();
      idle();
      chk("r0_wb_err", {31'b0, err_underflow}, 32'h0);
      chk("r0_wb_busy_vec", busy_vec, 32'h0);

      // Saturation on r5 at MAXP = 3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0);
         chk("sat5_fill_stall", {31'b0, stall}, 32'h0);
         tick();
      end
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0);
      chk("sat5_busy_vec", busy_vec, 32'h0000_0020);
      chk("sat5_full_stall", {31'b0, stall}, 32'h1);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd5);
      chk("sat5_retire_stall", {31'b0, stall}, 32'h0);
      tick();
      // Still at 3: a plain issue must stall again
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0);
      chk("sat5_still_full", {31'b0, stall}, 32'h1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5);
         tick();
      end
      idle();
      chk("sat5_drain2_vec", busy_vec, 32'h0000_0020);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5);
      tick();
      idle();
      chk("sat5_drain3_vec", busy_vec, 32'h0);
      chk("sat5_drain_err", {31'b0, err_underflow}, 32'h0);

      // Simultaneous issue and retire on r9 with cnt=1
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 5'd9);
      chk("sim9_stall", {31'b0, stall}, 32'h0);
      tick();
      idle();
      chk("sim9_busy_vec", busy_vec, 32'h0000_0200);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9);
      tick();
      idle();
      chk("sim9_one_left_vec", busy_vec, 32'h0);
      chk("sim9_err", {31'b0, err_underflow}, 32'h0);

      // Underflow on r7, sticky through later traffic
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7);
      tick();
      idle();
      chk("uf7_err", {31'b0, err_underflow}, 32'h1);
      chk("uf7_busy_vec", busy_vec, 32'h0);
      drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0);
      chk("uf7_no_wrap_stall", {31'b0, stall}, 32'h0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10);
      tick();
      idle();
      chk("uf_sticky_err", {31'b0, err_underflow}, 32'h1);
      chk("uf_sticky_vec", busy_vec, 32'h0);

      // Reset mid-operation with cnt[3]=2, cnt[4]=1
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0);
      tick();
      idle();
      chk("pre_rst_vec", busy_vec, 32'h0000_0018);
      reset = 1'b1;
      drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 5'd0);
      tick();
      reset = 1'b0;
      idle();
      chk("mid_rst_vec", busy_vec, 32'h0);
      chk("mid_rst_err", {31'b0, err_underflow}, 32'h0);
      drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 5'd0);
      chk("mid_rst_rs3_stall", {31'b0, stall}, 32'h0);
      tick();
      idle();
      chk("post_rst_vec", busy_vec, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
